// File: rtl/hex_disp_ctrl.sv
// hex_disp_ctrl: chooses the word shown on the 8-digit seven-segment scanner.
// The background is the live RTC word (with edit-mode blinking of selected
// digits); a message posted over req/ack temporarily replaces it for
// HOLD_CYC cycles.
//
// Message handshake: a request is accepted on any clock edge where
// msg_req = 1 and msg_ack = 0. msg_data is captured on that edge and msg_ack
// is high for exactly the following cycle, so a requester that keeps msg_req
// high is accepted every second cycle. A new accept while a message is
// showing replaces it and restarts the hold time.
//
// BLINK_HALF and HOLD_CYC must both be >= 2, and CNT_W must be wide enough
// to hold BLINK_HALF-1 and HOLD_CYC-1.
module hex_disp_ctrl #(
    parameter int BLINK_HALF = 12_500_000,
    parameter int HOLD_CYC   = 100_000_000,
    parameter int CNT_W      = 27
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] rtc_data,
    input  logic        edit_en,
    input  logic [7:0]  edit_mask,
    input  logic        msg_req,
    input  logic [31:0] msg_data,
    output logic        msg_ack,
    output logic        msg_busy,
    input  logic        disp_on,
    output logic [31:0] disp_data,
    output logic        disp_en,
    output logic        src
);

    typedef enum logic {
        S_RTC = 1'b0,
        S_MSG = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   hold_cnt_q,  hold_cnt_d;
    logic [31:0]        msg_word_q,  msg_word_d;
    logic [CNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic               blink_ph_q,  blink_ph_d;
    logic [31:0]        disp_data_q, disp_data_d;
    logic               disp_en_q,   disp_en_d;
    logic               msg_ack_q,   msg_ack_d;
    logic               msg_busy_q,  msg_busy_d;

    logic               accept;
    logic [31:0]        rtc_shown;

    // Message FSM: accept has priority over hold expiry, so a request landing
    // on the last hold cycle keeps the display on a message without an RTC gap.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        msg_word_d = msg_word_q;
        accept     = msg_req & ~msg_ack_q;
        if (accept) begin
            state_d    = S_MSG;
            hold_cnt_d = HOLD_LOAD;
            msg_word_d = msg_data;
        end else if (state_q == S_MSG) begin
            if (hold_cnt_q == '0) begin
                state_d = S_RTC;
            end else begin
                hold_cnt_d = hold_cnt_q - CNT_ONE;
            end
        end
    end

    // Blink timebase: held at phase 0 outside edit mode so every edit session
    // starts with the digits visible; runs regardless of FSM state.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (!edit_en) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_ph_d  = ~blink_ph_q;
        end else begin
            blink_cnt_d = blink_cnt_q + CNT_ONE;
        end
    end

    // RTC word with blinking digits replaced by 4'hF (rendered as '-').
    always_comb begin
        rtc_shown = rtc_data;
        for (int i = 0; i < 8; i++) begin
            if (edit_en && edit_mask[i] && blink_ph_q) begin
                rtc_shown[4*i +: 4] = 4'hF;
            end
        end
    end

    // Output word and flags follow the next state, so the cycle after an
    // accept already shows the message together with the ack pulse.
    always_comb begin
        disp_data_d = (state_d == S_MSG) ? msg_word_d : rtc_shown;
        disp_en_d   = disp_on;
        msg_ack_d   = accept;
        msg_busy_d  = (state_d == S_MSG);
    end

    // All state and registered outputs; reset drops any pending message.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_RTC;
            hold_cnt_q  <= '0;
            msg_word_q  <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            disp_data_q <= '0;
            disp_en_q   <= 1'b0;
            msg_ack_q   <= 1'b0;
            msg_busy_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            msg_word_q  <= msg_word_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            disp_data_q <= disp_data_d;
            disp_en_q   <= disp_en_d;
            msg_ack_q   <= msg_ack_d;
            msg_busy_q  <= msg_busy_d;
        end
    end

    assign disp_data = disp_data_q;
    assign disp_en   = disp_en_q;
    assign msg_ack   = msg_ack_q;
    assign msg_busy  = msg_busy_q;
    assign src       = msg_busy_q;

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Bench for hex_disp_ctrl with BLINK_HALF = 4, HOLD_CYC = 10.
// Expected output vectors {disp_data, disp_en, msg_ack, msg_busy, src} are
// queued with the cycle they belong to; a monitor compares on each falling edge.
module tb_hex_disp_ctrl;

    localparam int W = 36;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] rtc_data = '0;
    logic        edit_en = 1'b0;
    logic [7:0]  edit_mask = '0;
    logic        msg_req = 1'b0;
    logic [31:0] msg_data = '0;
    logic        disp_on = 1'b0;
    logic        msg_ack, msg_busy, disp_en, src;
    logic [31:0] disp_data;
    logic [W-1:0] act;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];
    int           exp_cyc_q[$];
    string        name_q[$];

    hex_disp_ctrl #(.BLINK_HALF(4), .HOLD_CYC(10), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .rtc_data(rtc_data), .edit_en(edit_en),
        .edit_mask(edit_mask), .msg_req(msg_req), .msg_data(msg_data),
        .msg_ack(msg_ack), .msg_busy(msg_busy), .disp_on(disp_on),
        .disp_data(disp_data), .disp_en(disp_en), .src(src)
    );

    // Clock and cycle index (cyc = number of rising edges so far)
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign act = {disp_data, disp_en, msg_ack, msg_busy, src};

    function automatic logic [W-1:0] pack(input logic [31:0] d, input logic en,
                                           input logic ack, input logic busy);
        return {d, en, ack, busy, busy};
    endfunction

    task automatic expect_at(input int k, input logic [W-1:0] v, input string nm);
        exp_cyc_q.push_back(k);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
                int           k;
                logic [W-1:0] e;
                string        nm;
                k  = exp_cyc_q.pop_front();
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (k < cyc) begin
                    failures++;
                    $display("FAIL %s: entry for cycle %0d checked late at cycle %0d", nm, k, cyc);
                end else if (act !== e) begin
                    failures++;
                    $display("FAIL %s cyc=%0d: got data=%h en=%b ack=%b busy=%b src=%b, want data=%h en=%b ack=%b busy=%b src=%b",
                             nm, cyc, act[35:4], act[3], act[2], act[1], act[0],
                             e[35:4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int t;
        int waited;

        // Reset, then RTC pass-through
        step();
        step();
        expect_at(cyc, '0, "reset_zero");
        rtc_data = 32'h1234_5678;
        disp_on  = 1'b1;
        step();
        expect_at(cyc, '0, "reset_ignores_inputs");
        rstn = 1'b1;
        expect_at(cyc + 1, pack(32'h1234_5678, 1'b1, 1'b0, 1'b0), "rtc_pass");
        step();
        rtc_data = 32'h8765_4321;
        expect_at(cyc + 1, pack(32'h8765_4321, 1'b1, 1'b0, 1'b0), "rtc_pass2");
        step();

        // Single message: shown exactly 10 cycles, data latched at accept
        t = cyc + 1;
        msg_req  = 1'b1;
        msg_data = 32'hDEAD_BEEF;
        expect_at(t, pack(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1), "msg_accept");
        for (int j = 1; j <= 9; j++)
            expect_at(t + j, pack(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1), "msg_hold");
        expect_at(t + 10, pack(32'h8765_4321, 1'b1, 1'b0, 1'b0), "msg_expire");
        step();
        msg_req  = 1'b0;
        msg_data = 32'h0BAD_0BAD;
        repeat (11) step();

        // Message replace restarts the hold
        t = cyc + 1;
        msg_req  = 1'b1;
        msg_data = 32'hDEAD_BEEF;
        expect_at(t, pack(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1), "repl_first");
        for (int j = 1; j <= 4; j++)
            expect_at(t + j, pack(32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1), "repl_first_hold");
        expect_at(t + 5, pack(32'hCAFE_0001, 1'b1, 1'b1, 1'b1), "repl_second");
        for (int j = 6; j <= 14; j++)
            expect_at(t + j, pack(32'hCAFE_0001, 1'b1, 1'b0, 1'b1), "repl_second_hold");
        expect_at(t + 15, pack(32'h8765_4321, 1'b1, 1'b0, 1'b0), "repl_expire");
        step();
        msg_req = 1'b0;
        repeat (4) step();
        msg_req  = 1'b1;
        msg_data = 32'hCAFE_0001;
        step();
        msg_req = 1'b0;
        repeat (11) step();

        // Continuous request: accepted every second cycle, never returns to RTC
        t = cyc + 1;
        msg_req = 1'b1;
        for (int j = 0; j < 24; j++) begin
            msg_data = 32'hA000_0000 + 32'(j);
            expect_at(t + j, pack(32'hA000_0000 + 32'((j / 2) * 2), 1'b1, (j % 2) == 0, 1'b1),
                      "cont_req");
            step();
        end
        msg_req = 1'b0;
        for (int j = 24; j <= 31; j++)
            expect_at(t + j, pack(32'hA000_0016, 1'b1, 1'b0, 1'b1), "cont_tail");
        expect_at(t + 32, pack(32'h8765_4321, 1'b1, 1'b0, 1'b0), "cont_expire");
        repeat (10) step();

        // Request on the expiry cycle wins over returning to RTC
        t = cyc + 1;
        msg_req  = 1'b1;
        msg_data = 32'h2222_0000;
        expect_at(t, pack(32'h2222_0000, 1'b1, 1'b1, 1'b1), "exp_first");
        for (int j = 1; j <= 9; j++)
            expect_at(t + j, pack(32'h2222_0000, 1'b1, 1'b0, 1'b1), "exp_first_hold");
        expect_at(t + 10, pack(32'h3333_0000, 1'b1, 1'b1, 1'b1), "exp_boundary_accept");
        for (int j = 11; j <= 19; j++)
            expect_at(t + j, pack(32'h3333_0000, 1'b1, 1'b0, 1'b1), "exp_second_hold");
        expect_at(t + 20, pack(32'h8765_4321, 1'b1, 1'b0, 1'b0), "exp_return");
        step();
        msg_req = 1'b0;
        repeat (9) step();
        msg_req  = 1'b1;
        msg_data = 32'h3333_0000;
        step();
        msg_req = 1'b0;
        repeat (11) step();

        // Blink: 4 visible / 4 dashed, message unmodified, mask change, edit off
        rtc_data = 32'h0012_3045;
        msg_data = 32'h4444_5555;
        for (int r = 0; r < 32; r++) begin
            logic [31:0] ew;
            edit_en   = (r < 30);
            edit_mask = (r < 26) ? 8'h03 : 8'hF0;
            msg_req   = (r == 12);
            if (r >= 12 && r <= 21)
                ew = 32'h4444_5555;
            else if (r >= 30 || ((r / 4) % 2) == 0)
                ew = 32'h0012_3045;
            else if (r >= 26)
                ew = 32'hFFFF_3045;
            else
                ew = 32'h0012_30FF;
            expect_at(cyc + 1, pack(ew, 1'b1, r == 12, r >= 12 && r <= 21), "blink");
            step();
        end
        msg_req = 1'b0;

        // Reset in the middle of a message
        t = cyc + 1;
        msg_req  = 1'b1;
        msg_data = 32'h5555_AAAA;
        expect_at(t, pack(32'h5555_AAAA, 1'b1, 1'b1, 1'b1), "rst_msg_accept");
        expect_at(t + 1, pack(32'h5555_AAAA, 1'b1, 1'b0, 1'b1), "rst_msg_hold");
        step();
        msg_req = 1'b0;
        step();
        step();
        rstn = 1'b0;
        expect_at(cyc, '0, "rst_mid_msg");
        step();
        expect_at(cyc, '0, "rst_mid_msg_held");
        rstn = 1'b1;
        expect_at(cyc + 1, pack(32'h0012_3045, 1'b1, 1'b0, 1'b0), "rst_recover");
        step();
        expect_at(cyc + 1, pack(32'h0012_3045, 1'b1, 1'b0, 1'b0), "rst_recover2");
        step();

        // disp_on low: enable drops, data and FSM keep running
        disp_on  = 1'b0;
        rtc_data = 32'h9876_5432;
        expect_at(cyc + 1, pack(32'h9876_5432, 1'b0, 1'b0, 1'b0), "disp_off");
        step();
        rtc_data = 32'hABCD_EF01;
        expect_at(cyc + 1, pack(32'hABCD_EF01, 1'b0, 1'b0, 1'b0), "disp_off_update");
        step();
        msg_req  = 1'b1;
        msg_data = 32'h6666_7777;
        expect_at(cyc + 1, pack(32'h6666_7777, 1'b0, 1'b1, 1'b1), "disp_off_msg");
        step();
        msg_req = 1'b0;
        disp_on = 1'b1;
        expect_at(cyc + 1, pack(32'h6666_7777, 1'b1, 1'b0, 1'b1), "disp_on_msg");
        step();

        // Drain the scoreboard with a bounded wait
        waited = 0;
        while (exp_q.size() > 0 && waited < 50) begin
            step();
            waited++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d entries still queued, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d, want end of stimulus", cyc);
        $fatal(1, "watchdog");
    end

endmodule
